// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// The optional early-exit behaviour is selected with SEQ_MAG_CMP_EARLY_EXIT_EN.
package seq_mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {gt,eq,lt} result bundle encodings
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Operand/result handshake bundle for seq_mag_comparator.
// slave = comparator side, master = producer/consumer side.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             busy;

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, gt, eq, lt, busy
  );

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, gt, eq, lt, busy
  );
endinterface

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             c_gt,
  output logic             c_eq,
  output logic             c_lt
);
  assign c_gt = (a_i >  b_i);
  assign c_eq = (a_i == b_i);
  assign c_lt = (a_i <  b_i);
endmodule

// File: rtl/seq_mag_comparator.sv
// MSB-first, CHUNK-bits-per-cycle magnitude comparator with valid/ready handshakes.
// Define SEQ_MAG_CMP_EARLY_EXIT_EN to finish at the first differing chunk.
module seq_mag_comparator
  import seq_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_mag_comparator_if.slave  bus
);

  localparam int              NCHUNK   = WIDTH / CHUNK;
  localparam int              IDXW     = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);
  // Flipping the MSB maps two's-complement onto offset binary, so unsigned compare works.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        res_q, res_d;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
  logic              decided_q, decided_d;
  logic [2:0]        dres_q, dres_d;
`endif

  logic [WIDTH-1:0]  a_sh, b_sh;
  logic              c_gt, c_eq, c_lt;
  logic [2:0]        cres;

  assign a_sh = a_q >> (CHUNK * int'(idx_q));
  assign b_sh = b_q >> (CHUNK * int'(idx_q));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_i  (a_sh[CHUNK-1:0]),
    .b_i  (b_sh[CHUNK-1:0]),
    .c_gt (c_gt),
    .c_eq (c_eq),
    .c_lt (c_lt)
  );

  assign cres = c_gt ? RES_GT : (c_lt ? RES_LT : RES_EQ);

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q == CMP);
  assign bus.out_valid = (state_q == DONE);
  assign {bus.gt, bus.eq, bus.lt} = res_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
    decided_d = decided_q;
    dres_d    = dres_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.is_signed ? (bus.a ^ MSB_MASK) : bus.a;
          b_d     = bus.is_signed ? (bus.b ^ MSB_MASK) : bus.b;
          idx_d   = IDX_LAST;
          state_d = CMP;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
          decided_d = 1'b0;
          dres_d    = '0;
`endif
        end
      end
      CMP: begin
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
        if (!c_eq || (idx_q == '0)) begin
          res_d   = cres;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        // Sticky first difference keeps latency constant regardless of data.
        if (!decided_q && !c_eq) begin
          decided_d = 1'b1;
          dres_d    = cres;
        end
        if (idx_q == '0) begin
          res_d   = decided_q ? dres_q : cres;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
      decided_q <= 1'b0;
      dres_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
      decided_q <= decided_d;
      dres_q    <= dres_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator (WIDTH=16, CHUNK=2), either macro setting.
module tb_seq_mag_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  res;
    int          lat_early;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic ov_prev = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  seq_mag_comparator_if #(.WIDTH(16)) bus ();

  seq_mag_comparator #(.WIDTH(16), .CHUNK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input int lat_early);
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
    return lat_early;
`else
    return 8;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: each new result is popped from the scoreboard and checked
  always @(negedge clk) begin
    if (bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid=1 with res %b, expected no result", {bus.gt, bus.eq, bus.lt});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'({bus.gt, bus.eq, bus.lt}), 32'(e.res));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic s,
                       input logic [2:0] r, input int lat, input bit push);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      chk("issue_timeout", 32'(g), 32'(0));
    end else begin
      bus.a         = ta;
      bus.b         = tb_;
      bus.is_signed = s;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (push) sb.push_back('{res: r, lat: lat, acc: cyc});
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.out_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("idle_timeout", 32'(g), 32'(0));
  endtask

  initial begin
    int g;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, GT, 1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, EQ, 8});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, LT, 1});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, GT, 1});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, LT, 1});
    vecs.push_back('{16'h0001, 16'h0002, 1'b0, LT, 8});
    vecs.push_back('{16'h0100, 16'h0200, 1'b0, LT, 4});
    vecs.push_back('{16'h0030, 16'h0010, 1'b0, GT, 6});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, EQ, 8});
    vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b1, LT, 8});
    vecs.push_back('{16'h0005, 16'hFFFB, 1'b1, GT, 1});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_res", 32'({bus.gt, bus.eq, bus.lt}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, exp_lat(vecs[i].lat_early), 1'b1);
      wait_idle();
    end

    // Backpressure: result held while out_ready is low, pending request not accepted
    bus.out_ready = 1'b0;
    issue(16'h0003, 16'h0001, 1'b0, GT, exp_lat(8), 1'b1);
    g = 0;
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("bp_wait_timeout", 32'(g), 32'(0));
    bus.a         = 16'h0100;
    bus.b         = 16'h0200;
    bus.is_signed = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_res_hold", 32'({bus.gt, bus.eq, bus.lt}), 32'(GT));
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ov", 32'(bus.out_valid), 32'(0));
    chk("bp_release_res", 32'({bus.gt, bus.eq, bus.lt}), 32'(0));
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb.push_back('{res: LT, lat: exp_lat(4), acc: cyc});
    wait_idle();

    // Reset in the middle of a compare (at idx=3), then a fresh compare
    issue(16'h5555, 16'h5555, 1'b0, EQ, 8, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_res", 32'({bus.gt, bus.eq, bus.lt}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
    repeat (10) @(negedge clk);
    issue(16'h0010, 16'h0010, 1'b0, EQ, exp_lat(8), 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Parametrised N-bit magnitude comparator. Replaces fixed-width 2-bit combinational compare in wider datapaths.
- Operands are compared MSB-first, CHUNK bits per clock, so wide compares need no long carry-style chains.
- Supports unsigned and two's-complement modes, selected per operation.
- Has valid/ready handshakes on input and result, so it can sit between pipelined producer and consumer stages.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of chunk steps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.
- busy  out  1  compare in progress (state CMP).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - State returns to IDLE.
  - gt/eq/lt/out_valid/busy = 0.
  - Operand registers and chunk index are cleared.
  - in_ready = 0 while rst is high, then 1 in the first cycle after.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: capture a, b, is_signed; load idx = NCHUNK-1; go to CMP.
  - Signed handling: when is_signed = 1, the MSB of both captured operands is inverted (offset-binary), so every chunk compare is unsigned.
- CMP:
  - in_ready = 0, busy = 1.
  - Each cycle compares chunk idx (bits [idx*CHUNK +: CHUNK]) of A and B.
  - The first differing chunk decides gt or lt. Later chunks never override it.
  - If all chunks are equal by idx = 0, the result is eq.
  - idx decrements by 1 per cycle. Leaving CMP loads gt/eq/lt and sets out_valid at the same edge.
- DONE:
  - out_valid = 1. Exactly one of gt/eq/lt is 1. All are held stable until out_valid & out_ready.
  - On that handshake edge: outputs go to 0 and state returns to IDLE.
  - in_ready rises the cycle after, so there is no overlap of result and new acceptance.
- Outside DONE: gt = eq = lt = 0.
- Latency, counted in edges from the accept edge to out_valid = 1:
  - Without the optional feature: exactly NCHUNK.
  - With it: see Optional Feature.
- in_valid is ignored outside IDLE. A source holding in_valid high is accepted only on return to IDLE.
- Reset mid-operation (in CMP or DONE): the operation is abandoned, no out_valid is produced, and the block is in IDLE the next cycle.
- out_ready while not in DONE is ignored.
- CHUNK = WIDTH: single-step compare, latency 1 edge.

Optional Feature:
- Macro: SEQ_MAG_CMP_EARLY_EXIT_EN.
- Defined:
  - CMP exits at the edge where the first differing chunk is evaluated.
  - Latency = (NCHUNK - k) edges, where k is the index of the most-significant differing chunk.
  - Equal operands still take NCHUNK edges.
- Undefined:
  - Constant latency of NCHUNK edges for every operand pair.
  - The first difference is recorded in a sticky decided flag plus result register.

Decomposition:
- Package seq_mag_cmp_pkg:
  - FSM state enum (IDLE, CMP, DONE).
  - Result encodings RES_GT = 3'b100, RES_EQ = 3'b010, RES_LT = 3'b001, for the {gt,eq,lt} bundle.
  - Function computing the idx width as clog2(NCHUNK), minimum 1.
- Sub-module chunk_cmp:
  - Purely combinational CHUNK-bit unsigned compare, outputs c_gt/c_eq/c_lt.
  - Instantiated once on the muxed current chunk.

Test Plan (WIDTH=16, CHUNK=2; each scenario runs under both macro settings):
- Unsigned MSB difference: a=0x8000, b=0x7FFF, is_signed=0 -> gt=1, eq=lt=0. out_valid after 1 edge (early exit) / 8 edges (no early exit).
- Equal operands: a=b=0x1234 -> eq=1 after 8 edges in both builds. gt=lt=0.
- Signed vs unsigned, a=0xFFFF, b=0x0001:
  - is_signed=1 -> lt=1.
  - is_signed=0 -> gt=1.
  - Signed a=0x8000, b=0x7FFF -> lt=1.
- LSB-only difference: a=0x0001, b=0x0002 -> lt=1 after 8 edges in both builds.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: gt/eq/lt stable, in_ready=0, pending in_valid not accepted.
  - Release out_ready: out_valid drops next edge; in_ready=1 the following cycle.
- Reset mid-CMP: assert rst at idx=3 -> next cycle busy=0, out_valid=0, outputs 0. A fresh compare a=0x0010, b=0x0010 then yields eq=1.
